// File: rtl/inv_test_seq.sv
// rtl/inv_test_seq.sv - quad inverter test sequencer: drives vectors, checks ~drv, counts errors.
// Optional LFSR stimulus enabled by defining LFSR_MODE_EN (default build uses a counter).
module inv_test_seq #(
    parameter int         NVEC = 100,
    parameter logic [3:0] SEED = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] drv,
    input  logic [3:0] rsp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [9:0] vec_cnt
);

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, CHECK, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] vec_cnt_inc;
    logic        last_vec;
    logic        accept;
    logic [3:0]  first_vec;
    logic [3:0]  next_vec;

    assign vec_cnt_inc = {1'b0, vec_cnt} + 11'd1;
    assign last_vec    = vec_cnt_inc >= 11'(NVEC);
    assign accept      = start && (state == IDLE || state == DONE);

`ifdef LFSR_MODE_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 0001.
    assign first_vec = (SEED == 4'b0000) ? 4'b0001 : SEED;
    assign next_vec  = {drv[2:0], drv[3] ^ drv[2]};
`else
    localparam logic [3:0] SEED_UNUSED = SEED;
    assign first_vec = 4'b0000;
    assign next_vec  = drv + 4'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? DONE : DRIVE;
            DONE:    if (start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // drv is loaded on the edge entering DRIVE, so it is stable through CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            drv     <= 4'd0;
            err_cnt <= 8'd0;
            vec_cnt <= 10'd0;
        end else if (accept) begin
            drv     <= first_vec;
            err_cnt <= 8'd0;
            vec_cnt <= 10'd0;
        end else if (state == CHECK) begin
            if (rsp != ~drv && err_cnt != 8'hff) begin
                err_cnt <= err_cnt + 8'd1;
            end
            vec_cnt <= vec_cnt_inc[9:0];
            if (!last_vec) begin
                drv <= next_vec;
            end
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_inv_test_seq.sv
// tb/tb_inv_test_seq.sv - scoreboard bench for inv_test_seq: queued expected vectors and run results.
module tb_inv_test_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] drv;
    logic [3:0] rsp;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [9:0] vec_cnt;

    logic       rst_sat;
    logic       start_sat;
    logic [3:0] drv_sat;
    logic       busy_sat, done_sat, pass_sat;
    logic [7:0] err_sat;
    logic [9:0] vec_sat;

    logic       stuck;
    int         checks = 0;
    int         failures = 0;

    logic [3:0]  exp_drv_q[$];
    logic [18:0] exp_res_q[$];

    always #5 clk = ~clk;

    assign rsp = stuck ? {~drv[3:1], 1'b0} : ~drv;

    inv_test_seq #(.NVEC(16), .SEED(4'b1001)) u_dut (
        .clk(clk), .rst(rst), .start(start), .drv(drv), .rsp(rsp),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt)
    );

    inv_test_seq #(.NVEC(300), .SEED(4'b0000)) u_sat (
        .clk(clk), .rst(rst_sat), .start(start_sat), .drv(drv_sat), .rsp(drv_sat),
        .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_cnt(err_sat), .vec_cnt(vec_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] v);
`ifdef LFSR_MODE_EN
        return {v[2:0], v[3] ^ v[2]};
`else
        return v + 4'd1;
`endif
    endfunction

    // Pushes the 16 expected vectors of a run and returns how many are even (stuck-at-0 on db hits those).
    task automatic push_run(output int evens);
        logic [3:0] v;
`ifdef LFSR_MODE_EN
        v = 4'b1001;
`else
        v = 4'b0000;
`endif
        evens = 0;
        for (int i = 0; i < 16; i++) begin
            exp_drv_q.push_back(v);
            if (v[0] == 1'b0) evens++;
            v = model_next(v);
        end
    endtask

    // Monitor: pops one expected vector per 3-cycle slot, and one result per done rising edge.
    int         bcnt = 0;
    int         phase = 0;
    logic [3:0] cur = 4'd0;
    logic       done_d = 1'b0;
    logic [18:0] r;

    always @(negedge clk) begin
        if (rst) begin
            exp_drv_q.delete();
            bcnt  = 0;
            phase = 0;
        end else begin
            if (busy) begin
                if (phase == 0) begin
                    if (exp_drv_q.size() == 0) chk("drv_queue_empty", 1, 0);
                    else cur = exp_drv_q.pop_front();
                end
                chk("drv", {28'd0, drv}, {28'd0, cur});
                phase = (phase == 2) ? 0 : phase + 1;
                bcnt++;
            end
            if (done && !done_d) begin
                chk("busy_cycles", bcnt, 48);
                if (exp_res_q.size() == 0) begin
                    chk("result_queue_empty", 1, 0);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("err_cnt", {24'd0, err_cnt}, {24'd0, r[18:11]});
                    chk("vec_cnt", {22'd0, vec_cnt}, {22'd0, r[10:1]});
                    chk("pass", {31'd0, pass}, {31'd0, r[0]});
                end
                bcnt  = 0;
                phase = 0;
            end
        end
        done_d = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run (from IDLE or DONE), optionally pulses start mid-run, and measures latency.
    task automatic do_run(input int errs, input logic exp_pass, input bit mid_start);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_err", {24'd0, err_cnt}, 32'd0);
        chk("clear_vec", {22'd0, vec_cnt}, 32'd0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
            if (mid_start && lat == 15) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        chk("done_latency", lat, 48);
    endtask

    int ev;
    int sat_lat;

    initial begin
        rst = 1'b1; rst_sat = 1'b1; start = 1'b0; start_sat = 1'b0; stuck = 1'b0;
        tick(); tick();
        chk("rst_drv", {28'd0, drv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        chk("rst_vec", {22'd0, vec_cnt}, 32'd0);
        rst = 1'b0; rst_sat = 1'b0;
        tick(); tick();
        chk("idle_hold_busy", {31'd0, busy}, 32'd0);

        start_sat = 1'b1;
        tick();
        start_sat = 1'b0;
`ifdef LFSR_MODE_EN
        chk("seed0_first_drv", {28'd0, drv_sat}, 32'h1);
`else
        chk("sat_first_drv", {28'd0, drv_sat}, 32'h0);
`endif
        sat_lat = 0;

        // Run A: good inverter.
        push_run(ev);
        exp_res_q.push_back({8'd0, 10'd16, 1'b1});
        do_run(0, 1'b1, 1'b0);

        // Run B: db stuck at 0, started from DONE, with an ignored start at vector 5.
        stuck = 1'b1;
        push_run(ev);
`ifdef LFSR_MODE_EN
        chk("lfsr_even_count", ev, 7);
`else
        chk("counter_even_count", ev, 8);
`endif
        exp_res_q.push_back({ev[7:0], 10'd16, 1'b0});
        do_run(ev, 1'b0, 1'b1);

        // Run C: good again from DONE, counters must clear from the faulty run.
        stuck = 1'b0;
        push_run(ev);
        exp_res_q.push_back({8'd0, 10'd16, 1'b1});
        do_run(0, 1'b1, 1'b0);

        // Run D: aborted by a 2-cycle reset.
        push_run(ev);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("abort_drv", {28'd0, drv}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {24'd0, err_cnt}, 32'd0);
        chk("abort_vec", {22'd0, vec_cnt}, 32'd0);
        repeat (5) tick();
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("abort_idle_done", {31'd0, done}, 32'd0);

        while (!done_sat && sat_lat < 1000) begin
            tick();
            sat_lat++;
        end
        chk("sat_done", {31'd0, done_sat}, 32'd1);
        chk("sat_err", {24'd0, err_sat}, 32'd255);
        chk("sat_vec", {22'd0, vec_sat}, 32'd300);
        chk("sat_pass", {31'd0, pass_sat}, 32'd0);
        chk("leftover_drv_q", exp_drv_q.size(), 0);
        chk("leftover_res_q", exp_res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
